// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache: hits complete in the request cycle, misses stall.
// BUSYWAIT holds the CPU through write-back, fetch and update; memory is paced by MEM_BUSYWAIT.
module dcache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  localparam int TAG_BITS = 6 - INDEX_BITS;
  localparam int NUM_BLOCKS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t state;

  logic [31:0]         data_array [NUM_BLOCKS];
  logic [TAG_BITS-1:0] tag_array  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;

  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] index;
  logic [1:0]            offset;
  logic [TAG_BITS-1:0]   lat_tag;
  logic [INDEX_BITS-1:0] lat_index;

  logic       hit;
  logic       req;
  logic       idle_hit;
  logic [7:0] hit_byte;
  logic [7:0] read_hold;
  logic       seen_busy;
  logic       mem_done;

  assign tag    = ADDRESS[7 -: TAG_BITS];
  assign index  = ADDRESS[2 +: INDEX_BITS];
  assign offset = ADDRESS[1:0];

  assign hit      = valid[index] && (tag_array[index] == tag);
  assign req      = READ | WRITE;
  assign idle_hit = (state == IDLE) && hit;
  assign hit_byte = data_array[index][{offset, 3'b000} +: 8];

  assign BUSYWAIT = req & ~idle_hit;
  // A store with READ also high is a store, so it never drives load data.
  assign READDATA = (READ && !WRITE && idle_hit) ? hit_byte : read_hold;

  // Memory finishes once it has been seen busy and then drops busy.
  assign mem_done = seen_busy & ~MEM_BUSYWAIT;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      seen_busy     <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      read_hold     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            if (WRITE) begin
              data_array[index][{offset, 3'b000} +: 8] <= WRITEDATA;
              dirty[index] <= 1'b1;
            end else begin
              read_hold <= hit_byte;
            end
          end else if (req) begin
            lat_tag   <= tag;
            lat_index <= index;
            if (dirty[index]) begin
              state         <= WRITEBACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {tag_array[index], index};
              MEM_WRITEDATA <= data_array[index];
            end else begin
              state       <= FETCH;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {tag, index};
            end
          end
        end
        WRITEBACK: begin
          if (MEM_BUSYWAIT) seen_busy <= 1'b1;
          if (mem_done) begin
            seen_busy     <= 1'b0;
            state         <= FETCH;
            MEM_WRITE     <= 1'b0;
            MEM_READ      <= 1'b1;
            MEM_ADDRESS   <= {lat_tag, lat_index};
            MEM_WRITEDATA <= '0;
          end
        end
        FETCH: begin
          if (MEM_BUSYWAIT) seen_busy <= 1'b1;
          if (mem_done) begin
            seen_busy   <= 1'b0;
            state       <= UPDATE;
            MEM_READ    <= 1'b0;
            MEM_ADDRESS <= '0;
          end
        end
        UPDATE: begin
          data_array[lat_index] <= MEM_READDATA;
          tag_array[lat_index]  <= lat_tag;
          valid[lat_index]      <= 1'b1;
          dirty[lat_index]      <= 1'b0;
          state                 <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
